// File: rtl/fifo_stream.sv
// Single-clock valid/ready FIFO with first-word-fall-through registered output,
// occupancy level, almost flags and flush. Define FIFO_STATS_EN for refused-push/empty-pop counters.
module fifo_stream #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [15:0]           overflow_cnt,
  output logic [15:0]           underflow_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LVL   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_LVL   = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]   level_reg, level_next;
  logic                  out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  push, pop;

  // in_ready depends only on registered level, so a pop never frees a slot in the same cycle
  assign in_ready = (level_reg != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_reg && out_ready;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    out_data_next  = out_data_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (push && !pop)      level_next = level_reg + LVL_ONE;
      else if (pop && !push) level_next = level_reg - LVL_ONE;
      // Head comes from the input when the queue is (or becomes) otherwise empty, else from storage
      if (push && ((level_reg == '0) || (pop && level_reg == LVL_ONE)))
        out_data_next = in_data;
      else if (pop && (level_reg > LVL_ONE))
        out_data_next = mem[rd_ptr_next];
    end
    out_valid_next = (level_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= in_data;
  end

  assign out_data     = out_data_reg;
  assign out_valid    = out_valid_reg;
  assign level        = level_reg;
  assign almost_full  = (level_reg >= AF_LVL);
  assign almost_empty = (level_reg <= AE_LVL);

`ifdef FIFO_STATS_EN
  logic [15:0] ovf_reg, unf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= '0;
      unf_reg <= '0;
    end else begin
      if (in_valid && !in_ready && !flush && (ovf_reg != 16'hFFFF))
        ovf_reg <= ovf_reg + 16'd1;
      if (out_ready && !out_valid_reg && !flush && (unf_reg != 16'hFFFF))
        unf_reg <= unf_reg + 16'd1;
    end
  end

  assign overflow_cnt  = ovf_reg;
  assign underflow_cnt = unf_reg;
`else
  assign overflow_cnt  = '0;
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream.sv
// Self-checking bench for fifo_stream: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_fifo_stream;
  localparam int DW = 64;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   level;
  logic          almost_full, almost_empty;
  logic [15:0]   overflow_cnt, underflow_cnt;

  fifo_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit cmp_en  = 1'b0;

`ifdef FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Reference model: a queue holding the contents, oldest first
  logic [DW-1:0] q[$];
  logic [DW-1:0] out_exp = '0;
  int ovf_m = 0, unf_m = 0;
  int n_m;
  bit push_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      out_exp = '0;
      ovf_m = 0;
      unf_m = 0;
    end else begin
      n_m = q.size();
      push_m = in_valid && (n_m < DEPTH);
      if (flush) begin
        q.delete();
      end else begin
        if (in_valid && !push_m && ovf_m < 65535) ovf_m++;
        if (out_ready && n_m == 0 && unf_m < 65535) unf_m++;
        if (out_ready && n_m > 0) void'(q.pop_front());
        if (push_m) q.push_back(in_data);
      end
      if (q.size() > 0) out_exp = q[0];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_level", DW'(level), DW'(q.size()));
      chk("m_out_valid", DW'(out_valid), DW'(q.size() != 0));
      chk("m_out_data", out_data, out_exp);
      chk("m_in_ready", DW'(in_ready), DW'(q.size() != DEPTH));
      chk("m_almost_full", DW'(almost_full), DW'(q.size() >= 3));
      chk("m_almost_empty", DW'(almost_empty), DW'(q.size() <= 1));
      chk("m_overflow", DW'(overflow_cnt), STATS ? DW'(ovf_m) : '0);
      chk("m_underflow", DW'(underflow_cnt), STATS ? DW'(unf_m) : '0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
  endtask

  initial begin
    logic [DW-1:0] drain_exp [4];
    drain_exp[0] = 64'h2; drain_exp[1] = 64'h3; drain_exp[2] = 64'h4; drain_exp[3] = 64'h5;

    // Reset
    cyc(); cyc();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_level", DW'(level), 0);
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", DW'(in_ready), 1);
    chk("rst_almost_empty", DW'(almost_empty), 1);
    chk("rst_almost_full", DW'(almost_full), 0);

    // Single push, FWFT latency
    drive(1, 64'hA1, 0, 0); cyc();
    drive(0, 0, 0, 0);
    chk("a1_out_valid", DW'(out_valid), 1);
    chk("a1_out_data", out_data, 64'hA1);
    chk("a1_level", DW'(level), 1);
    chk("a1_almost_empty", DW'(almost_empty), 1);
    drive(0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0);
    chk("a1_drained", DW'(level), 0);

    // Fill to full, then one refused push
    for (int i = 1; i <= 4; i++) begin
      drive(1, DW'(i), 0, 0); cyc();
      if (i == 3) chk("fill_af_at3", DW'(almost_full), 1);
    end
    chk("full_level", DW'(level), 4);
    chk("full_in_ready", DW'(in_ready), 0);
    chk("full_out_data", out_data, 64'h1);
    drive(1, 64'h5, 0, 0); cyc();
    chk("refused_level", DW'(level), 4);
    chk("overflow_one", DW'(overflow_cnt), STATS ? 1 : 0);

    // Full with push and pop: only the pop happens
    drive(1, 64'h5, 1, 0); cyc();
    chk("fullpop_level", DW'(level), 3);
    chk("fullpop_head", out_data, 64'h2);
    drive(1, 64'h5, 0, 0); cyc();
    chk("refill_level", DW'(level), 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0);
      chk("wrap_drain", out_data, drain_exp[i]);
      cyc();
    end
    drive(0, 0, 0, 0);
    chk("wrap_empty", DW'(out_valid), 0);

    // Level 2 with simultaneous push and pop
    drive(1, 64'h11, 0, 0); cyc();
    drive(1, 64'h22, 0, 0); cyc();
    drive(1, 64'hBB, 1, 0); cyc();
    chk("pp_level", DW'(level), 2);
    chk("pp_head", out_data, 64'h22);
    drive(0, 0, 1, 0); cyc();
    chk("pp_last", out_data, 64'hBB);
    cyc();
    drive(0, 0, 0, 0);
    chk("pp_empty", DW'(level), 0);

    // Flush at level 3 with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'h31 + DW'(i), 0, 0); cyc();
    end
    drive(1, 64'hCC, 0, 1); cyc();
    drive(0, 0, 0, 0);
    chk("flush_level", DW'(level), 0);
    chk("flush_out_valid", DW'(out_valid), 0);
    chk("flush_in_ready", DW'(in_ready), 1);
    chk("flush_out_hold", out_data, 64'h31);

    // Pops on empty
    drive(0, 0, 1, 0); cyc(); cyc(); cyc();
    drive(0, 0, 0, 0);
    chk("underflow_three", DW'(underflow_cnt), STATS ? 3 : 0);
    chk("underflow_level", DW'(level), 0);

    // Async reset mid-stream at level 2
    drive(1, 64'h77, 0, 0); cyc();
    drive(1, 64'h78, 0, 0); cyc();
    drive(0, 0, 0, 0);
    chk("prerst_level", DW'(level), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_level", DW'(level), 0);
    chk("async_out_valid", DW'(out_valid), 0);
    chk("async_out_data", out_data, 0);
    chk("async_overflow", DW'(overflow_cnt), 0);
    cyc();
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, {$urandom, $urandom},
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
      cyc();
    end
    drive(0, 0, 0, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
